// File: rtl/mod_counter_gen_if.sv
// Control and status bundle for mod_counter_gen: enables, load, direction, modulus select
// on the master side; count value and derived flags on the slave side.
interface mod_counter_gen_if #(
  parameter int WIDTH = 26
);
  logic             enp;
  logic             ent;
  logic             ld;
  logic             up;
  logic             use_mod;
  logic [WIDTH-1:0] mod_val;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rco;
  logic             wrap;
  logic             half;
  logic             tog;

  modport master (
    output enp, ent, ld, up, use_mod, mod_val, d,
    input  q, rco, wrap, half, tog
  );

  modport slave (
    input  enp, ent, ld, up, use_mod, mod_val, d,
    output q, rco, wrap, half, tog
  );
endinterface

// File: rtl/mod_counter_gen.sv
// Up/down modulo counter with runtime modulus, cascade ripple-carry, one-cycle wrap pulse,
// half-period flag and wrap toggle; a zero modulus means the full 2**WIDTH range.
module mod_counter_gen #(
  parameter int              WIDTH   = 26,
  parameter longint unsigned DEF_MOD = 64'd50_000_000
) (
  input logic           clk,
  input logic           rst_n,
  mod_counter_gen_if.slave bus
);

  // Modulus arithmetic is one bit wider so that M = 2**WIDTH is representable.
  localparam logic [WIDTH:0] DEF_M  = (WIDTH+1)'(DEF_MOD);
  localparam logic [WIDTH:0] FULL_M = {1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0] q;
  logic             wrap;
  logic             tog;

  logic [WIDTH:0]   m_raw;
  logic [WIDTH:0]   m_eff;
  logic [WIDTH:0]   m_last;
  logic [WIDTH:0]   q_ext;
  logic             tc_up;
  logic             tc_dn;
  logic             tc;
  logic             count_en;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    m_raw    = bus.use_mod ? {1'b0, bus.mod_val} : DEF_M;
    m_eff    = (m_raw == '0) ? FULL_M : m_raw;
    m_last   = m_eff - (WIDTH+1)'(1);
    q_ext    = {1'b0, q};
    // ">=" rather than "==" so an out-of-range load or a shrunk modulus wraps on the next count
    tc_up    = (q_ext >= m_last);
    tc_dn    = (q == '0);
    tc       = bus.up ? tc_up : tc_dn;
    count_en = bus.enp & bus.ent;
    if (bus.up) begin
      q_next = tc_up ? '0 : q + WIDTH'(1);
    end else begin
      q_next = tc_dn ? m_last[WIDTH-1:0] : q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
      tog  <= 1'b0;
    end else if (!bus.ld) begin
      q    <= bus.d;
      wrap <= 1'b0;
    end else if (count_en) begin
      q    <= q_next;
      wrap <= tc;
      if (tc) begin
        tog <= ~tog;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign bus.q    = q;
  assign bus.wrap = wrap;
  assign bus.tog  = tog;
  // Ripple carry follows ENT only, so a cascaded stage sees the carry even while ENP pauses.
  assign bus.rco  = bus.ent & tc;
  assign bus.half = (q_ext >= (m_eff >> 1));

endmodule
